ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between NUM_M bus masters: JTAG debug module (M0), UART debug loader (M1),

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_rr_pick.sv | 39 +++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
package ram_arbiter_pkg;

  // Arbiter sequencing: pick an owner, issue one RAM beat, acknowledge it.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // Width of a master index; never zero even for a single master.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first requester strictly
// above i_ptr wins, wrapping around to index 0 when none is above.
module ram_arbiter_rr_pick #(
  parameter int NUM_M = 3,
  parameter int PW    = 2
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [NUM_M-1:0] o_gnt,
  output logic [PW-1:0]    o_idx,
  output logic             o_valid
);

  logic [NUM_M-1:0] w_mask;
  logic [NUM_M-1:0] w_req_hi;
  logic [NUM_M-1:0] w_pick_src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_mask
      assign w_mask[gi] = (PW'(gi) > i_ptr);
    end
  endgenerate

  // Requesters above the pointer take precedence; otherwise wrap to all.
  assign w_req_hi   = i_req & w_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : i_req;
  assign o_gnt      = w_pick_src & (-w_pick_src);
  assign o_valid    = |i_req;

  // Convert the one-hot winner into an index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (o_gnt[i]) o_idx = PW'(i);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM among NUM_M masters: round-robin grant,
// optional locked bursts capped at LOCK_MAX beats, one ack per beat, and a
// stall (hold_o) for the core while its access is outstanding.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_M    = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16,
  parameter int CORE_IDX = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_we,
  input  logic [NUM_M-1:0]    m_lock,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_ack,
  output logic [DW-1:0]       m_rdata,
  output logic                s_req,
  output logic                s_we,
  output logic [AW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  input  logic [DW-1:0]       s_rdata,
  output logic [NUM_M-1:0]    grant_o,
  output logic                hold_o
);

  localparam int PW = idx_w(NUM_M);
  localparam int CW = $clog2(LOCK_MAX) + 1;

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_owner;
  logic [NUM_M-1:0] r_grant;
  logic [CW-1:0]    r_lock_cnt;
  logic             r_s_req;
  logic             r_s_we;
  logic [AW-1:0]    r_s_addr;
  logic [DW-1:0]    r_s_wdata;

  logic [NUM_M-1:0] w_win_gnt;
  logic [PW-1:0]    w_win_idx;
  logic             w_win_valid;
  logic [PW-1:0]    w_cap_idx;
  logic             w_load;
  logic             w_reload;
  logic             w_release;
  logic             w_lock_ok;
  logic [AW-1:0]    w_addr_arr  [NUM_M];
  logic [DW-1:0]    w_wdata_arr [NUM_M];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = m_addr[gi*AW +: AW];
      assign w_wdata_arr[gi] = m_wdata[gi*DW +: DW];
    end
  endgenerate

  ram_arbiter_rr_pick #(
    .NUM_M (NUM_M),
    .PW    (PW)
  ) u_rr_pick (
    .i_req   (m_req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_win_gnt),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  // A new grant captures the winner's beat; a burst continuation recaptures the owner's.
  assign w_cap_idx = (r_state == ARB_IDLE) ? w_win_idx : r_owner;
  assign w_lock_ok = m_lock[r_owner] & m_req[r_owner] & (r_lock_cnt < CW'(LOCK_MAX - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and capture/release strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_reload     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_win_valid) begin
          w_load       = 1'b1;
          w_state_next = ARB_ACCESS;
        end
      end
      ARB_ACCESS: w_state_next = ARB_RESP;
      ARB_RESP: begin
        if (w_lock_ok) begin
          w_reload     = 1'b1;
          w_state_next = ARB_ACCESS;
        end else begin
          w_release    = 1'b1;
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // Ownership, burst counting and the registered RAM-side beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= PW'(NUM_M - 1);
      r_owner    <= '0;
      r_grant    <= '0;
      r_lock_cnt <= '0;
      r_s_req    <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
    end else begin
      r_s_req <= (w_state_next == ARB_ACCESS);
      if (w_load) begin
        r_grant    <= w_win_gnt;
        r_owner    <= w_win_idx;
        r_lock_cnt <= '0;
      end
      if (w_load || w_reload) begin
        r_s_we    <= m_we[w_cap_idx];
        r_s_addr  <= w_addr_arr[w_cap_idx];
        r_s_wdata <= w_wdata_arr[w_cap_idx];
      end
      if (w_reload) r_lock_cnt <= r_lock_cnt + CW'(1);
      if (w_release) begin
        r_rr_ptr   <= r_owner;
        r_lock_cnt <= '0;
        r_grant    <= '0;
      end
    end
  end

  assign s_req   = r_s_req;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign grant_o = r_grant;
  assign m_ack   = (r_state == ARB_RESP) ? r_grant : '0;
  assign m_rdata = (r_state == ARB_RESP && !r_s_we) ? s_rdata : '0;
  assign hold_o  = m_req[CORE_IDX] & ~m_ack[CORE_IDX];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model of the arbitration rules.
module tb_ram_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LM = 4;
  localparam int CI = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req, m_we, m_lock, m_ack;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata, s_wdata, s_rdata;
  logic             s_req, s_we, hold_o;
  logic [AW-1:0]    s_addr;
  logic [NM-1:0]    grant_o;

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .LOCK_MAX(LM), .CORE_IDX(CI)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .grant_o(grant_o), .hold_o(hold_o)
  );

  // Master-side drive values, packed onto the DUT buses.
  logic [AW-1:0] drv_addr  [NM];
  logic [DW-1:0] drv_wdata [NM];
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW]  = drv_addr[i];
      m_wdata[i*DW +: DW] = drv_wdata[i];
    end
  end

  // RAM stand-in: 16 words, read data one cycle after s_req; bench preload port.
  logic [31:0] ram [16];
  logic        tb_wr;
  logic [3:0]  tb_wa;
  logic [31:0] tb_wd;
  always @(posedge clk) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (s_req) begin
      if (s_we) ram[s_addr[5:2]] <= s_wdata;
      else      s_rdata <= ram[s_addr[5:2]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: owner, beats in the current burst, scheduled beat/ack cycles.
  bit          busy;
  logic [1:0]  owner;
  int          beats, last_win, sreq_at, resp_at;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [31:0] ref_mem [16];
  int          beats_left [NM];
  bit          eager;
  int          ack_m[$];
  int          ack_c[$];
  logic [31:0] last_rd [NM];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0; owner = '0; beats = 0; last_win = NM - 1; sreq_at = -1; resp_at = -1;
  endtask

  task automatic set_beat(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0] ii;
    ii = 2'(i);
    m_req[ii] = 1'b1; m_we[ii] = we; drv_addr[ii] = addr; drv_wdata[ii] = wd;
  endtask

  task automatic rand_beat(input int i);
    set_beat(i, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2, $urandom);
  endtask

  task automatic capture();
    cap_we = m_we[owner]; cap_addr = drv_addr[owner]; cap_wdata = drv_wdata[owner];
  endtask

  function automatic int q_at(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1000;
  endfunction

  // One clock: model decision on the inputs of this cycle, edge, check, then masters react.
  task automatic run_cycle();
    logic [NM-1:0] exp_ack, exp_grant;
    logic [31:0]   exp_rd;
    logic [1:0]    c;
    if (!busy) begin
      if (|m_req) begin
        for (int k = NM; k >= 1; k--) begin
          c = 2'((last_win + k) % NM);
          if (m_req[c]) owner = c;
        end
        busy = 1'b1; beats = 1; capture(); sreq_at = cyc + 1; resp_at = cyc + 2;
      end
    end else if (cyc == resp_at) begin
      if (m_lock[owner] && m_req[owner] && beats < LM) begin
        beats++; capture(); sreq_at = cyc + 1; resp_at = cyc + 2;
      end else begin
        last_win = int'(owner); busy = 1'b0;
      end
    end
    @(posedge clk); #1; cyc++;
    exp_ack = '0;   if (cyc == resp_at) exp_ack[owner] = 1'b1;
    exp_grant = '0; if (busy) exp_grant[owner] = 1'b1;
    check_eq("m_ack", m_ack, exp_ack);
    check_eq("grant_o", grant_o, exp_grant);
    check_eq("s_req", s_req, cyc == sreq_at);
    check_eq("hold_o", hold_o, m_req[CI] & ~exp_ack[CI]);
    if (cyc == sreq_at) begin
      check_eq("s_we", s_we, cap_we);
      check_eq("s_addr", s_addr, cap_addr);
      if (cap_we) check_eq("s_wdata", s_wdata, cap_wdata);
    end
    if (cyc == resp_at) begin
      exp_rd = cap_we ? 32'h0 : ref_mem[cap_addr[5:2]];
      check_eq("m_rdata", m_rdata, exp_rd);
      if (cap_we) ref_mem[cap_addr[5:2]] = cap_wdata;
      last_rd[owner] = m_rdata;
      $display("[TB] cyc %0d M%0d %s addr=0x%08h data=0x%08h", cyc, owner,
               cap_we ? "WR" : "RD", cap_addr, cap_we ? cap_wdata : m_rdata);
    end
    for (int i = 0; i < NM; i++) begin
      if (m_ack[i]) begin ack_m.push_back(i); ack_c.push_back(cyc); end
    end
    for (int i = 0; i < NM; i++) begin
      if (exp_ack[i]) begin
        beats_left[i]--;
        if (beats_left[i] > 0 && (eager || $urandom_range(0, 1) == 1)) rand_beat(i);
        else m_req[i] = 1'b0;
      end else if (!m_req[i] && beats_left[i] > 0 && !eager && $urandom_range(0, 2) == 0) begin
        rand_beat(i);
      end
    end
  endtask

  initial begin
    int t0, guard;
    logic [31:0] d;
    rst = 1'b0; m_req = '0; m_we = '0; m_lock = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0; eager = 1'b1;
    for (int i = 0; i < NM; i++) begin
      drv_addr[i] = '0; drv_wdata[i] = '0; beats_left[i] = 0; last_rd[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_req", s_req, 1'b0);
    check_eq("rst_m_ack", m_ack, 3'b000);
    check_eq("rst_grant", grant_o, 3'b000);
    check_eq("rst_rdata", m_rdata, 32'h0);
    m_req[2] = 1'b1; #1;
    check_eq("rst_hold_hi", hold_o, 1'b1);
    m_req[2] = 1'b0; #1;
    check_eq("rst_hold_lo", hold_o, 1'b0);
    for (int i = 0; i < 16; i++) begin
      d = (i == 4) ? 32'hDEADBEEF : $urandom;
      tb_wr = 1'b1; tb_wa = 4'(i); tb_wd = d; ref_mem[i] = d;
      @(posedge clk); #1;
    end
    tb_wr = 1'b0;
    rst = 1'b1;

    // Single read by the core.
    ack_m.delete(); ack_c.delete();
    beats_left[2] = 1; set_beat(2, 1'b0, 32'h10, 32'h0); t0 = cyc;
    repeat (4) run_cycle();
    check_eq("t1_ack_count", ack_c.size(), 1);
    check_eq("t1_latency", q_at(ack_c, 0) - t0, 2);
    check_eq("t1_rdata", last_rd[2], 32'hDEADBEEF);

    // Reset while the beat is on the RAM bus.
    beats_left[1] = 1; set_beat(1, 1'b0, 32'h4, 32'h0);
    run_cycle();
    rst = 1'b0; #1;
    check_eq("t6_s_req", s_req, 1'b0);
    check_eq("t6_m_ack", m_ack, 3'b000);
    check_eq("t6_grant", grant_o, 3'b000);
    m_req = '0; beats_left[1] = 0; model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Three-way contention straight after reset.
    ack_m.delete(); ack_c.delete();
    for (int i = 0; i < NM; i++) begin beats_left[i] = 1; rand_beat(i); end
    t0 = cyc;
    repeat (10) run_cycle();
    check_eq("t2_ack_count", ack_m.size(), 3);
    check_eq("t2_first_latency", q_at(ack_c, 0) - t0, 2);
    for (int j = 0; j < 3; j++) check_eq("t2_order", q_at(ack_m, j), j);
    for (int j = 1; j < 3; j++) check_eq("t2_gap", q_at(ack_c, j) - q_at(ack_c, j - 1), 3);

    // M0 and M2 requesting continuously, no lock.
    ack_m.delete(); ack_c.delete();
    beats_left[0] = 4; beats_left[2] = 4; rand_beat(0); rand_beat(2);
    repeat (30) run_cycle();
    check_eq("t3_ack_count", ack_m.size(), 8);
    for (int j = 0; j < 8; j++) check_eq("t3_alternate", q_at(ack_m, j), (j % 2 == 0) ? 0 : 2);

    // Locked M1 burst capped at LOCK_MAX, M2 waiting.
    ack_m.delete(); ack_c.delete();
    m_lock[1] = 1'b1; beats_left[1] = 6; beats_left[2] = 1; rand_beat(1); rand_beat(2);
    repeat (30) run_cycle();
    check_eq("t4_ack_count", ack_m.size(), 7);
    for (int j = 0; j < 4; j++) check_eq("t4_burst_owner", q_at(ack_m, j), 1);
    check_eq("t4_m2_after", q_at(ack_m, 4), 2);
    for (int j = 1; j < 4; j++) check_eq("t4_burst_gap", q_at(ack_c, j) - q_at(ack_c, j - 1), 2);
    check_eq("t4_release_gap", q_at(ack_c, 4) - q_at(ack_c, 3), 3);
    m_lock = '0;

    // Write by M0, read back by M2.
    beats_left[0] = 1; set_beat(0, 1'b1, 32'h20, 32'h12345678);
    repeat (5) run_cycle();
    beats_left[2] = 1; set_beat(2, 1'b0, 32'h20, 32'h0);
    repeat (5) run_cycle();
    check_eq("t5_readback", last_rd[2], 32'h12345678);

    // Randomized traffic with random per-master lock.
    eager = 1'b0;
    m_lock = 3'($urandom_range(0, 7));
    for (int i = 0; i < NM; i++) beats_left[i] = $urandom_range(5, 15);
    repeat (300) run_cycle();
    guard = 0;
    while ((beats_left[0] > 0 || beats_left[1] > 0 || beats_left[2] > 0 || busy) && guard < 2000) begin
      run_cycle();
      guard++;
    end
    check_eq("drain_in_time", guard < 2000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
